mem_ctrl: RTL

Memory access controller: the initiator side of the CPU's single-port synchronous RAM interface (12-bit word address, 16-bit data, registered read, write-enable). Arbitrates between the CPU instruction-fetch port and data port, drives one RAM access at a time, and returns read data with a one-cycle valid pulse. Sits between the CPU core and the RAM instance.

---
 rtl/cpu_mem_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 54 +++++
 rtl/mem_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU-side RAM access controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    // One RAM transaction walks IDLE -> ACCESS -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester identity; also used as the index into the grant vector.
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

endpackage

// File: rtl/mem_arbiter.sv
// Picks fetch or data port for the next RAM access; data has priority, fetch is forced after a data streak.
// Latency: grant is combinational in the cycle arbitration is enabled.
// Backpressure: no grant while arb_en is low; requesters hold their request until granted.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en,
    input  logic       if_req,
    input  logic       d_req,
    output logic [1:0] gnt
);

    localparam int CNT_W = $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

    logic [CNT_W-1:0] streak;
    logic             fetch_forced;

    // Fixed priority to data, except a starving fetch that has waited out a full streak.
    always_comb begin
        gnt          = '0;
        fetch_forced = if_req && (streak == STREAK_MAX);
        if (arb_en) begin
            if (fetch_forced) begin
                gnt[PORT_IF] = 1'b1;
            end else if (d_req) begin
                gnt[PORT_D] = 1'b1;
            end else if (if_req) begin
                gnt[PORT_IF] = 1'b1;
            end
        end
    end

    // Count data grants that went past a waiting fetch; any uncontended grant resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (gnt[PORT_IF]) begin
            streak <= '0;
        end else if (gnt[PORT_D]) begin
            if (!if_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Initiator for the single-port registered RAM: arbitrates fetch/data ports and runs one access at a time.
// Latency: accept edge E, RAM access during E..E+1, rvalid pulse during E+1..E+2; one access per 3 cycles.
// Backpressure: grants only in IDLE; a losing or blocked requester simply keeps its request asserted.
module mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W     = cpu_mem_pkg::DATA_W,
    parameter int MAX_STREAK = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        gnt;
    logic              accept;
    logic              arb_en;

    port_t             lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    assign arb_en = (state == IDLE);
    assign accept = |gnt;
    assign if_gnt = gnt[PORT_IF];
    assign d_gnt  = gnt[PORT_D];

    // The latched request drives the RAM bus directly, so address/data hold outside ACCESS.
    assign ram_addr    = lat_addr;
    assign ram_data_in = lat_wdata;

    mem_arbiter #(
        .MAX_STREAK (MAX_STREAK)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_en (arb_en),
        .if_req (if_req),
        .d_req  (d_req),
        .gnt    (gnt)
    );

    // State register; async reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus decoded RAM strobe and response pulses (all gated by state so reset kills them at once).
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_we    = lat_we;
                state_nxt = RESP;
            end
            RESP: begin
                if (lat_port == PORT_D) begin
                    d_rvalid = 1'b1;
                    d_rdata  = ram_data_out;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = ram_data_out;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winning request on the accept edge; requesters are free to change afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_port  <= PORT_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            if (gnt[PORT_D]) begin
                lat_port  <= PORT_D;
                lat_we    <= d_we;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
            end else begin
                // Fetches never write; write data keeps its previous value.
                lat_port  <= PORT_IF;
                lat_we    <= 1'b0;
                lat_addr  <= if_addr;
            end
        end
    end

endmodule
